// File: rtl/instr_feeder_pkg.sv
// rtl/instr_feeder_pkg.sv - shared widths, FSM state type and padding helper for the instruction feeder
package instr_feeder_pkg;

    localparam int REG_WIDTH        = 16;
    localparam int INSTRUCTION_SIZE = 11;
    localparam int PAD_WIDTH        = REG_WIDTH - INSTRUCTION_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } feeder_state_t;

    // Zero-extend an instruction word to the core's register width
    function automatic logic [REG_WIDTH-1:0] pad_instr(input logic [INSTRUCTION_SIZE-1:0] word);
        return {{PAD_WIDTH{1'b0}}, word};
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// rtl/instr_feeder_if.sv - host write and core issue handshake bundle
interface instr_feeder_if;
    import instr_feeder_pkg::*;

    logic [INSTRUCTION_SIZE-1:0] wr_data;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [REG_WIDTH-1:0]        instr_out;
    logic                        instr_valid;
    logic                        done;

    // Host and core side: offers words, receives issued instructions
    modport master (
        output wr_data, wr_valid, done,
        input  wr_ready, instr_out, instr_valid
    );

    // Feeder side
    modport slave (
        input  wr_data, wr_valid, done,
        output wr_ready, instr_out, instr_valid
    );
endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - power-of-two instruction queue with flush and guarded push/pop
module instr_fifo
    import instr_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [INSTRUCTION_SIZE-1:0]   push_data,
    input  logic                          pop,
    output logic [INSTRUCTION_SIZE-1:0]   pop_data,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [INSTRUCTION_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        push_ok;
    logic                        pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    // A write racing a flush is dropped; pops never underflow
    assign push_ok  = push && !full && !flush;
    assign pop_ok   = pop && !empty && !flush;

    // Storage array; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - queues host instructions and issues them one at a time to the core
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        run,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        busy,
    output logic                        hang_err,
    instr_feeder_if.slave               bus
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    feeder_state_t               state, state_next;
    logic [INSTRUCTION_SIZE-1:0] instr_reg, instr_next;
    logic [WW-1:0]               wait_cnt, wait_next;
    logic                        hang_set;
    logic                        pop;
    logic [INSTRUCTION_SIZE-1:0] pop_data;
    logic                        full;
    logic                        empty;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (bus.wr_valid),
        .push_data (bus.wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.wr_ready    = !full;
    assign bus.instr_valid = (state == ISSUE);
    assign bus.instr_out   = (state == ISSUE) ? pad_instr(instr_reg) : '0;
    assign busy            = (state != IDLE);

    // State, held instruction, wait counter and sticky hang flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            instr_reg <= '0;
            wait_cnt  <= '0;
            hang_err  <= 1'b0;
        end else begin
            state     <= state_next;
            instr_reg <= instr_next;
            wait_cnt  <= wait_next;
            if (hang_set) hang_err <= 1'b1;
        end
    end

    // Next-state: pop into ISSUE from IDLE or GAP, leave ISSUE on done or timeout
    always_comb begin
        state_next = state;
        instr_next = instr_reg;
        wait_next  = wait_cnt;
        hang_set   = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (run && !empty && !flush) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                    instr_next = pop_data;
                    wait_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                // run and flush are deliberately ignored: an issued word always completes or times out
                if (bus.done) begin
                    state_next = GAP;
                    wait_next  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = IDLE;
                    wait_next  = '0;
                    hang_set   = 1'b1;
                end else begin
                    wait_next  = wait_cnt + WW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - directed table-driven bench for instr_feeder
module tb_instr_feeder;
    import instr_feeder_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       run;
    logic [3:0] count;
    logic       busy;
    logic       hang_err;

    int errors = 0;
    int checks = 0;

    instr_feeder_if bif ();

    instr_feeder #(.DEPTH(8), .TIMEOUT(255)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .run      (run),
        .count    (count),
        .busy     (busy),
        .hang_err (hang_err),
        .bus      (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [10:0] wd;
        logic        run;
        logic        done;
        logic        e_valid;
        logic [15:0] e_out;
        logic [3:0]  e_count;
        logic        e_busy;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [10:0] w);
        bif.wr_valid = 1'b1;
        bif.wr_data  = w;
        tick();
        bif.wr_valid = 1'b0;
    endtask

    // Runs until queue is empty and FSM idle, collecting every issued word
    task automatic drain(output logic [15:0] got [$], input int limit);
        got = {};
        for (int i = 0; i < limit; i++) begin
            if (count == 4'd0 && !busy) return;
            tick();
            if (bif.instr_valid) got.push_back(bif.instr_out);
        end
        check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] got [$];
        logic [10:0] a [10];
        int idx;
        int n;

        reset = 1'b0; flush = 1'b0; run = 1'b0;
        bif.wr_valid = 1'b0; bif.wr_data = '0; bif.done = 1'b0;
        repeat (3) tick();
        check("rst_valid", bif.instr_valid, 0);
        check("rst_out", bif.instr_out, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_hang", hang_err, 0);
        check("rst_ready", bif.wr_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Three words, done two cycles after each instr_valid rise
        vecs[0]  = '{1'b1, 11'h101, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0};
        vecs[1]  = '{1'b1, 11'h202, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd2, 1'b0};
        vecs[2]  = '{1'b1, 11'h303, 1'b1, 1'b0, 1'b1, 16'h0101, 4'd2, 1'b1};
        vecs[3]  = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 16'h0101, 4'd2, 1'b1};
        vecs[4]  = '{1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd2, 1'b1};
        vecs[5]  = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 16'h0202, 4'd1, 1'b1};
        vecs[6]  = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 16'h0202, 4'd1, 1'b1};
        vecs[7]  = '{1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd1, 1'b1};
        vecs[8]  = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 16'h0303, 4'd0, 1'b1};
        vecs[9]  = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 16'h0303, 4'd0, 1'b1};
        vecs[10] = '{1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1};
        vecs[11] = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            bif.wr_valid = vecs[i].wv;
            bif.wr_data  = vecs[i].wd;
            run          = vecs[i].run;
            bif.done     = vecs[i].done;
            tick();
            check($sformatf("vec%0d_valid", i), bif.instr_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_out", i), bif.instr_out, vecs[i].e_out);
            check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
        end
        bif.wr_valid = 1'b0; bif.done = 1'b0;

        // Fill to full with run low, overflow attempt, then FIFO order on release
        run = 1'b0;
        for (int i = 0; i < 8; i++) write_word(11'h010 + 11'(i));
        check("full_count", count, 8);
        check("full_ready", bif.wr_ready, 0);
        write_word(11'h7FF);
        check("overflow_count", count, 8);
        run = 1'b1;
        tick();
        check("first_out", bif.instr_out, 16'h0010);
        check("first_count", count, 7);
        bif.done = 1'b1;
        drain(got, 200);
        check("full_drain_n", got.size(), 7);
        for (int i = 0; i < 7 && i < got.size(); i++)
            check($sformatf("full_order%0d", i), got[i], 16'h0011 + 16'(i));

        // Simultaneous push/pop at count 4, then wrap pointers over 10 words
        run = 1'b0; bif.done = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) a[i] = 11'h400 + 11'(i * 17);
        for (int i = 0; i < 4; i++) write_word(a[i]);
        check("pre_pushpop_count", count, 4);
        bif.wr_valid = 1'b1; bif.wr_data = a[4]; run = 1'b1;
        tick();
        check("pushpop_count", count, 4);
        check("pushpop_out", bif.instr_out, pad_instr(a[0]));
        bif.done = 1'b1;
        idx = 5;
        got = {};
        for (int i = 0; i < 300; i++) begin
            if (idx == 10 && count == 4'd0 && !busy) break;
            if (idx < 10 && bif.wr_ready) begin
                bif.wr_valid = 1'b1; bif.wr_data = a[idx]; idx++;
            end else begin
                bif.wr_valid = 1'b0;
            end
            tick();
            if (bif.instr_valid) got.push_back(bif.instr_out);
        end
        bif.wr_valid = 1'b0;
        check("wrap_n", got.size(), 9);
        for (int i = 0; i < 9 && i < got.size(); i++)
            check($sformatf("wrap_order%0d", i), got[i], pad_instr(a[i+1]));

        // Timeout: done held low for the whole wait window
        run = 1'b0; bif.done = 1'b0;
        tick();
        write_word(11'h055);
        run = 1'b1;
        tick();
        check("hang_issue_out", bif.instr_out, 16'h0055);
        run = 1'b0;
        n = 0;
        while (bif.instr_valid && n < 400) begin
            tick();
            n++;
        end
        check("hang_cycles", n, 255);
        check("hang_err_set", hang_err, 1);
        check("hang_busy", busy, 0);
        check("hang_out", bif.instr_out, 0);
        bif.done = 1'b1; tick(); bif.done = 1'b0; tick();
        check("late_done_busy", busy, 0);
        check("late_done_valid", bif.instr_valid, 0);
        check("hang_sticky", hang_err, 1);

        // Flush with a racing write while an instruction is in ISSUE
        write_word(11'h7FF);
        for (int i = 0; i < 5; i++) write_word(11'h020 + 11'(i));
        check("pre_flush_count", count, 6);
        run = 1'b1;
        tick();
        check("flush_issue_out", bif.instr_out, 16'h07FF);
        check("flush_issue_count", count, 5);
        flush = 1'b1; bif.wr_valid = 1'b1; bif.wr_data = 11'h123;
        tick();
        flush = 1'b0; bif.wr_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_held_out", bif.instr_out, 16'h07FF);
        tick(); tick();
        check("flush_hold_out", bif.instr_out, 16'h07FF);
        check("flush_hold_count", count, 0);
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        check("flush_gap_valid", bif.instr_valid, 0);
        tick();
        check("flush_idle_busy", busy, 0);
        check("flush_idle_count", count, 0);

        // Asynchronous reset in the middle of ISSUE
        run = 1'b0;
        write_word(11'h111);
        write_word(11'h222);
        run = 1'b1;
        tick();
        check("pre_rst_valid", bif.instr_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", bif.instr_valid, 0);
        check("async_rst_out", bif.instr_out, 0);
        check("async_rst_count", count, 0);
        check("async_rst_hang", hang_err, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_count", count, 0);
        check("post_rst_valid", bif.instr_valid, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_hang", hang_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
